sat_counter_main: RTL and testbench

- Top-level demo block driving a saturating up/down counter from two push-buttons.
- btn1 presses increment the counter and btn2 presses decrement it; the count sticks at its limits and never wraps.
- Two status LEDs show when the counter sits at its upper or lower limit.
- Sits directly under the FPGA pin wrapper: buttons come from board pins (asynchronous), LEDs go to board pins.

---
 rtl/sat_counter_main_pkg.sv | 9 +
 rtl/btn_edge.sv | 28 ++
 rtl/sat_counter.sv | 37 +++
 rtl/sat_counter_main.sv | 50 +++++
 tb/tb_sat_counter_main.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sat_counter_main_pkg.sv
// Shared helpers for the saturating button counter demo.
package sat_counter_main_pkg;

  // Largest value representable in a counter of the given bit count.
  function automatic int unsigned cnt_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button front end: 2-flop synchronizer, history flop, registered one-cycle press pulse.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  // Everything resets to "released" so a button held through reset still yields one press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_prev  <= 1'b1;
      o_press <= 1'b0;
    end else begin
      r_s1    <= i_btn_n;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      o_press <= r_prev & ~r_s2;
    end
  end

endmodule

// File: rtl/sat_counter.sv
// Up/down counter that sticks at 0 and at its all-ones maximum.
module sat_counter
  import sat_counter_main_pkg::*;
#(
  parameter int unsigned width = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           inc,
  input  logic           dec,
  output logic [width:0] count
);

  localparam int unsigned CW = width + 1;
  localparam logic [CW-1:0] MAX = CW'(cnt_max(CW));

  logic [CW-1:0] w_next;

  // Simultaneous inc and dec cancel out; limits hold silently.
  always_comb begin
    w_next = count;
    if (inc && !dec && (count != MAX)) begin
      w_next = count + CW'(1);
    end else if (dec && !inc && (count != '0)) begin
      w_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= w_next;
    end
  end

endmodule

// File: rtl/sat_counter_main.sv
// Demo top: two active-low buttons step a saturating counter; LEDs flag its limits.
module sat_counter_main
  import sat_counter_main_pkg::*;
#(
  parameter int unsigned width = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn1,
  input  logic btn2,
  output logic led_r,
  output logic led_g
);

  localparam int unsigned CW = width + 1;
  localparam logic [CW-1:0] MAX = CW'(cnt_max(CW));

  logic          w_inc;
  logic          w_dec;
  logic [CW-1:0] w_count;

  btn_edge u_btn_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn_n (btn1),
    .o_press (w_inc)
  );

  btn_edge u_btn_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn_n (btn2),
    .o_press (w_dec)
  );

  sat_counter #(
    .width (width)
  ) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc),
    .dec   (w_dec),
    .count (w_count)
  );

  // LEDs decode the count register directly so they track it without delay.
  assign led_r = (w_count == MAX);
  assign led_g = (w_count == '0);

endmodule

// File: tb/tb_sat_counter_main.sv
// Self-checking bench for sat_counter_main: directed table, corner sequences, random vs model.
module tb_sat_counter_main;

  localparam int unsigned W    = 1;
  localparam int          MAXV = (1 << (W + 1)) - 1;
  localparam int          LAT  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic btn1  = 1'b1;
  logic btn2  = 1'b1;
  logic led_r;
  logic led_g;

  int n_total = 0;
  int n_pass  = 0;

  sat_counter_main #(.width(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn1  (btn1),
    .btn2  (btn2),
    .led_r (led_r),
    .led_g (led_g)
  );

  always #5 clk = ~clk;

  // Reference model: a press is a 1->0 change of the level seen at a clock edge,
  // and it takes effect LAT edges later with saturating arithmetic.
  typedef struct packed {
    logic inc;
    logic dec;
  } ev_t;

  int   m_count;
  logic m_p1;
  logic m_p2;
  ev_t  m_q[$];

  always @(posedge clk or negedge rst_n) begin : model
    ev_t e;
    ev_t d;
    if (!rst_n) begin
      m_count = 0;
      m_p1    = 1'b1;
      m_p2    = 1'b1;
      m_q.delete();
    end else begin
      if (m_q.size() == LAT) begin
        d = m_q.pop_front();
        if (d.inc && !d.dec && m_count < MAXV) m_count = m_count + 1;
        else if (d.dec && !d.inc && m_count > 0) m_count = m_count - 1;
      end
      e.inc = m_p1 & ~btn1;
      e.dec = m_p2 & ~btn2;
      m_p1  = btn1;
      m_p2  = btn2;
      m_q.push_back(e);
    end
  end

  typedef struct {
    logic b1;
    logic b2;
    int   exp_count;
    logic exp_r;
    logic exp_g;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_model(input string name);
    check({name, "_count"}, int'(dut.w_count), m_count);
    check({name, "_led_r"}, int'(led_r), int'(m_count == MAXV));
    check({name, "_led_g"}, int'(led_g), int'(m_count == 0));
  endtask

  task automatic check_const(input string name, input int c, input logic r, input logic g);
    check({name, "_count"}, int'(dut.w_count), c);
    check({name, "_led_r"}, int'(led_r), int'(r));
    check({name, "_led_g"}, int'(led_g), int'(g));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic p1, input logic p2);
    btn1 = ~p1;
    btn2 = ~p2;
    cyc(10);
    btn1 = 1'b1;
    btn2 = 1'b1;
    cyc(10);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      vecs[i]     = '{1'b1, 1'b0, (i < 3) ? i + 1 : 3, (i >= 2), 1'b0};
      vecs[i + 5] = '{1'b0, 1'b1, (i < 3) ? 2 - i : 0, 1'b0, (i >= 2)};
    end

    // Reset asserted before any clock edge: values must appear asynchronously.
    #1 rst_n = 1'b0;
    #1 check_const("reset_async", 0, 1'b0, 1'b1);
    cyc(2);
    check_const("reset_held", 0, 1'b0, 1'b1);
    rst_n = 1'b1;
    cyc(20);
    check_const("reset_idle", 0, 1'b0, 1'b1);

    // Saturating up then down via the table.
    for (int i = 0; i < 10; i++) begin
      press(vecs[i].b1, vecs[i].b2);
      check_const($sformatf("table%0d", i), vecs[i].exp_count, vecs[i].exp_r, vecs[i].exp_g);
      check_model($sformatf("table%0d_m", i));
    end

    // Exact latency and hold-low behaviour from count 0.
    btn1 = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      cyc(1);
      check($sformatf("latency_edge%0d", k), int'(dut.w_count), 0);
    end
    cyc(1);
    check("latency_update", int'(dut.w_count), 1);
    cyc(96);
    check_const("hold_low", 1, 1'b0, 1'b0);
    btn1 = 1'b1;
    cyc(20);
    check_const("hold_release", 1, 1'b0, 1'b0);

    // Both buttons falling together cancel.
    press(1'b1, 1'b1);
    check_const("simultaneous", 1, 1'b0, 1'b0);

    // Async reset mid-run with a press in flight.
    press(1'b1, 1'b0);
    check_const("pre_reset", 2, 1'b0, 1'b0);
    btn1 = 1'b0;
    cyc(1);
    #2 rst_n = 1'b0;
    #1 check_const("mid_reset_async", 0, 1'b0, 1'b1);
    cyc(2);
    btn1 = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    check_const("after_reset", 0, 1'b0, 1'b1);

    // Random button activity against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(7) == 0) btn1 = ~btn1;
      if ($urandom_range(7) == 0) btn2 = ~btn2;
      cyc(1);
      check_model($sformatf("rand%0d", c));
    end
    btn1 = 1'b1;
    btn2 = 1'b1;
    cyc(10);
    check_model("rand_settle");

    // Button already low when reset releases counts as one press.
    rst_n = 1'b0;
    btn1  = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    check_const("low_at_release", 1, 1'b0, 1'b0);
    btn1 = 1'b1;
    cyc(10);
    check_model("low_at_release_m");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
